// File: rtl/dawson32_seq_pkg.sv
// dawson32_seq_pkg
//   Shared types and widths for the Dawson 32-bit FP operand sequencer.
//   - seq_state_t : sequencer FSM states
//   - FP_W        : IEEE-754 single-precision word width
//   - CNT_W       : completed-operation counter width
package dawson32_seq_pkg;

  localparam int FP_W  = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    START = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO with a registered occupancy count.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     push, wdata  : write request and data (ignored when full)
//     pop          : read request (ignored when empty)
//     rdata        : head entry (show-ahead, zero after reset)
//     count        : number of stored entries, 0..DEPTH
//     full, empty  : flags decoded from the registered count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the show-ahead head reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/dawson32_seq.sv
// dawson32_seq
//   Operand sequencer in front of the Dawson 32-bit FP interface block.
//   Ports:
//     clock, reset_n                 : clock, asynchronous active-low reset
//     op_a, op_b, op_valid, op_ready : operand-pair input stream
//     res, res_valid, res_ready      : result output stream (show-ahead head)
//     if_a, if_b, if_ready_in        : request side of the interface block
//     if_out, if_ready_out           : response side of the interface block
//     busy                           : FSM in ISSUE or WAIT
//     timeout_err                    : sticky watchdog flag, cleared by reset only
//     done_count                     : results pushed into the result FIFO (wraps)
module dawson32_seq
  import dawson32_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [FP_W-1:0]   op_a,
  input  logic [FP_W-1:0]   op_b,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [FP_W-1:0]   res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP_W-1:0]   if_a,
  output logic [FP_W-1:0]   if_b,
  output logic              if_ready_in,
  input  logic [FP_W-1:0]   if_out,
  input  logic              if_ready_out,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  done_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_t         state_q, state_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   done_q, done_d;

  logic               op_push_s, op_pop_s;
  logic [2*FP_W-1:0]  op_head_s;
  logic [CW-1:0]      op_count_s;
  logic               op_full_s, op_empty_s;

  logic               res_push_s, res_pop_s;
  logic [CW-1:0]      res_count_s;
  logic               res_full_s, res_empty_s;
  logic [CW:0]        res_next_cnt_s;
  logic               can_issue_s, can_issue_next_s;

  assign op_push_s  = op_valid & ~op_full_s;
  assign op_pop_s   = (state_q == ISSUE);
  assign res_push_s = (state_q == WAIT) & if_ready_out;
  assign res_pop_s  = ~res_empty_s & res_ready;

  sync_fifo #(.WIDTH(2*FP_W), .DEPTH(DEPTH)) u_op_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (op_push_s),
    .pop   (op_pop_s),
    .wdata ({op_a, op_b}),
    .rdata (op_head_s),
    .count (op_count_s),
    .full  (op_full_s),
    .empty (op_empty_s)
  );

  sync_fifo #(.WIDTH(FP_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (res_push_s),
    .pop   (res_pop_s),
    .wdata (if_out),
    .rdata (res),
    .count (res_count_s),
    .full  (res_full_s),
    .empty (res_empty_s)
  );

  // A result slot must be guaranteed before issuing, since only one op is in flight.
  // can_issue_next is only evaluated in WAIT, where the operand FIFO is never popped,
  // so a non-zero count means a pair is ready for the back-to-back ISSUE.
  assign res_next_cnt_s   = {1'b0, res_count_s} + {{CW{1'b0}}, 1'b1}
                          - {{CW{1'b0}}, res_pop_s};
  assign can_issue_s      = ~op_empty_s & ~res_full_s;
  assign can_issue_next_s = (op_count_s != {CW{1'b0}}) && (res_next_cnt_s < (CW+1)'(DEPTH));

  // Sequencer next-state, watchdog and completion counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    case (state_q)
      START: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (can_issue_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = {WW{1'b0}};
      end
      WAIT: begin
        if (if_ready_out) begin
          done_d = done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (can_issue_next_s) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_q == WW'(TIMEOUT)) begin
          // Counter saturates; the flag stays set until reset.
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + {{(WW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= START;
      wait_q    <= {WW{1'b0}};
      timeout_q <= 1'b0;
      done_q    <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign op_ready    = ~op_full_s;
  assign res_valid   = ~res_empty_s;
  assign if_ready_in = (state_q == ISSUE);
  assign if_a        = (state_q == ISSUE) ? op_head_s[2*FP_W-1:FP_W] : {FP_W{1'b0}};
  assign if_b        = (state_q == ISSUE) ? op_head_s[FP_W-1:0]      : {FP_W{1'b0}};
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign timeout_err = timeout_q;
  assign done_count  = done_q;

endmodule

// File: tb/tb_dawson32_seq.sv
// tb_dawson32_seq
//   Randomized scoreboard bench for dawson32_seq with a 5-cycle adder stub
//   standing in for the FP interface block.
module tb_dawson32_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] op_a, op_b;
  logic        op_valid, op_ready;
  logic [31:0] res;
  logic        res_valid, res_ready;
  logic [31:0] if_a, if_b, if_out;
  logic        if_ready_in, if_ready_out;
  logic        busy, timeout_err;
  logic [15:0] done_count;

  dawson32_seq dut (
    .clock(clock), .reset_n(reset_n),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .if_a(if_a), .if_b(if_b), .if_ready_in(if_ready_in),
    .if_out(if_out), .if_ready_out(if_ready_out),
    .busy(busy), .timeout_err(timeout_err), .done_count(done_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_push_cyc = 0;
  int n_accepted = 0;
  bit stub_hang = 1'b0;
  logic [31:0] exp_res_q[$];
  logic [63:0] exp_iss_q[$];
  int issue_log[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Single-precision encode of a small non-negative integer (exact below 2^24).
  function automatic logic [31:0] int2fp(input int unsigned n);
    int p;
    logic [31:0] nv, m;
    logic [7:0] e;
    if (n == 0) return 32'h0;
    nv = n;
    p = 0;
    for (int i = 0; i < 32; i++) if (nv[i]) p = i;
    m = nv << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  // Decode an integer-valued single-precision word.
  function automatic int unsigned fp2int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_op_ready"},    {31'h0, op_ready},    32'h1);
    chk({tag, "_res_valid"},   {31'h0, res_valid},   32'h0);
    chk({tag, "_res"},         res,                  32'h0);
    chk({tag, "_if_ready_in"}, {31'h0, if_ready_in}, 32'h0);
    chk({tag, "_if_a"},        if_a,                 32'h0);
    chk({tag, "_if_b"},        if_b,                 32'h0);
    chk({tag, "_busy"},        {31'h0, busy},        32'h0);
    chk({tag, "_timeout"},     {31'h0, timeout_err}, 32'h0);
    chk({tag, "_done"},        {16'h0, done_count},  32'h0);
  endtask

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clock);
      if (op_ready) begin
        ok = 1'b1;
        exp_res_q.push_back(exp);
        exp_iss_q.push_back({a, b});
        last_push_cyc = cyc;
        n_accepted++;
      end
      @(posedge clock);
      #1;
    end
    op_valid = 1'b0;
    if (!ok) fail_now("push_accept_timeout");
  endtask

  task automatic push_rand();
    int unsigned x, y;
    x = $urandom_range(1, 100000);
    y = $urandom_range(1, 100000);
    push_pair(int2fp(x), int2fp(y), int2fp(x + y));
  endtask

  task automatic drain(input string nm, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clock);
      if (exp_res_q.size() == 0 && !busy && !res_valid) ok = 1'b1;
    end
    if (!ok) fail_now({nm, "_drain_timeout"});
    @(posedge clock);
    #1;
  endtask

  // Adder stub: answers each ready_in pulse 5 cycles later with a one-cycle ready_out.
  initial begin
    int cnt;
    bit pend;
    logic [31:0] sa, sb;
    pend = 1'b0;
    cnt = 0;
    sa = 32'h0;
    sb = 32'h0;
    if_ready_out = 1'b0;
    if_out = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend = 1'b0;
        if_ready_out = 1'b0;
        if_out = 32'h0;
      end else begin
        if (if_ready_out) if_ready_out = 1'b0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            if (!stub_hang) begin
              if_out = int2fp(fp2int(sa) + fp2int(sb));
              if_ready_out = 1'b1;
            end
          end
        end
        if (if_ready_in) begin
          pend = 1'b1;
          cnt = 5;
          sa = if_a;
          sb = if_b;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every result pop and every issue pulse.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (res_valid && res_ready) begin
          if (exp_res_q.size() == 0) fail_now("res_unexpected");
          else chk("res", res, exp_res_q.pop_front());
        end
        if (if_ready_in) begin
          issue_log.push_back(cyc);
          if (exp_iss_q.size() == 0) begin
            fail_now("issue_unexpected");
          end else begin
            e = exp_iss_q.pop_front();
            chk("if_a", if_a, e[63:32]);
            chk("if_b", if_b, e[31:0]);
          end
        end else begin
          chk("if_ab_idle", if_a | if_b, 32'h0);
        end
      end
    end
  end

  initial begin
    int ic;
    op_valid = 1'b0;
    op_a = 32'h0;
    op_b = 32'h0;
    res_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_vals("rst");
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Single operation from IDLE: 1.0 + 2.0 = 3.0
    issue_log.delete();
    push_pair(32'h3F800000, 32'h40000000, 32'h40400000);
    drain("single", 60);
    chk("single_issue_count", issue_log.size(), 32'd1);
    if (issue_log.size() > 0) chk("single_issue_latency", issue_log[0], last_push_cyc + 2);
    chk("single_done", {16'h0, done_count}, 32'd1);

    // Back-to-back: 4 pairs on consecutive cycles, no bubble between ready_out and ISSUE
    issue_log.delete();
    for (int i = 0; i < 4; i++) push_rand();
    drain("b2b", 100);
    chk("b2b_issue_count", issue_log.size(), 32'd4);
    for (int i = 1; i < 4 && i < issue_log.size(); i++)
      chk("b2b_issue_gap", issue_log[i] - issue_log[i-1], 32'd6);
    chk("b2b_done", {16'h0, done_count}, 32'd5);

    // Back-pressure: 10 pairs with the consumer stalled
    res_ready = 1'b0;
    n_accepted = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_rand();
      end
    join_none
    repeat (80) @(posedge clock);
    @(negedge clock);
    chk("bp_accepted", n_accepted, 32'd8);
    chk("bp_op_ready", {31'h0, op_ready}, 32'h0);
    chk("bp_res_valid", {31'h0, res_valid}, 32'h1);
    chk("bp_busy", {31'h0, busy}, 32'h0);
    chk("bp_done", {16'h0, done_count}, 32'd9);
    @(posedge clock);
    #1 res_ready = 1'b1;
    wait fork;
    drain("bp", 200);
    chk("bp_accepted_all", n_accepted, 32'd10);
    chk("bp_done_all", {16'h0, done_count}, 32'd15);

    // Timeout: stub never answers
    stub_hang = 1'b1;
    issue_log.delete();
    push_rand();
    for (int i = 0; i < 20 && issue_log.size() == 0; i++) @(negedge clock);
    if (issue_log.size() == 0) begin
      fail_now("to_no_issue");
    end else begin
      ic = issue_log[0];
      for (int i = 0; i < 400 && cyc < ic + 256; i++) @(negedge clock);
      chk("to_not_yet", {31'h0, timeout_err}, 32'h0);
      @(negedge clock);
      chk("to_set", {31'h0, timeout_err}, 32'h1);
      chk("to_busy", {31'h0, busy}, 32'h1);
      repeat (5) @(negedge clock);
      chk("to_sticky", {31'h0, timeout_err}, 32'h1);
      chk("to_still_wait", {31'h0, busy & ~if_ready_in}, 32'h1);
    end
    @(posedge clock);
    #1;
    push_rand();
    push_rand();

    // Reset mid-operation, then a fresh op starting in the START cycle
    reset_n = 1'b0;
    exp_res_q.delete();
    exp_iss_q.delete();
    stub_hang = 1'b0;
    @(negedge clock);
    check_reset_vals("midrst");
    @(posedge clock);
    #1 reset_n = 1'b1;
    issue_log.delete();
    push_pair(32'h3F800000, 32'h40000000, 32'h40400000);
    drain("post_rst", 60);
    chk("post_rst_issue_count", issue_log.size(), 32'd1);
    if (issue_log.size() > 0) chk("post_rst_issue_latency", issue_log[0], last_push_cyc + 2);
    chk("post_rst_done", {16'h0, done_count}, 32'd1);

    // Random traffic with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clock);
          #1 push_rand();
        end
      end
      begin
        repeat (400) begin
          @(posedge clock);
          #1 res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    drain("rand", 300);
    chk("rand_done", {16'h0, done_count}, 32'd31);
    chk("rand_timeout_clear", {31'h0, timeout_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
